// File: rtl/game_pkg.sv
// Shared types and constants for the brick-breaker round controller.
package game_pkg;

    localparam int BRICK_COUNT      = 56;
    localparam int LIVES_W          = 2;
    localparam int TICK_DIV_DEFAULT = 25000000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SERVE  = 3'd2,
        ST_PLAY   = 3'd3,
        ST_LOST   = 3'd4,
        ST_WIN    = 3'd5,
        ST_OVER   = 3'd6,
        ST_PAUSED = 3'd7
    } state_e;

endpackage

// File: rtl/game_sequencer_tick_divider.sv
// Game-step divider: counts 0..TICK_DIV-1 while enabled, freezes on hold,
// and registers a one-cycle tick aligned with the terminal count.
module tick_divider #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // en/clr/hold describe the upcoming cycle, so tick_q lines up with cnt_q.
    always_comb begin
        cnt_d = '0;
        if (clr)
            cnt_d = '0;
        else if (hold)
            cnt_d = cnt_q;
        else if (en)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        tick_d = en && !hold && !clr && (cnt_d == LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/game_sequencer.sv
// Brick-breaker round controller: owns the game tick and sequences rounds.
// Optional pause in PLAY is enabled by defining GAME_PAUSE_EN.
module game_sequencer
    import game_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_DEFAULT,
    parameter int LIVES       = 3,
    parameter int SERVE_TICKS = 4,
    parameter int LOAD_CYCLES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start_btn,
    input  logic [BRICK_COUNT-1:0] bricks,
    input  logic                   ball_lost,
    output logic                   tick,
    output logic                   field_reset_n,
    output logic                   ball_hold,
    output logic [LIVES_W-1:0]     lives,
    output logic [2:0]             state,
    output logic                   game_over,
    output logic                   win
);

    localparam int                 PH_W     = $clog2(LOAD_CYCLES + SERVE_TICKS + 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    state_e             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic               start_q, start_edge;
    logic               frn_q, hold_q, over_q, win_q;
    logic               div_en, div_clr, div_hold, tick_w;

    assign start_edge = start_btn & ~start_q;

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        unique case (state_q)
            ST_IDLE: if (start_edge) begin
                state_d = ST_LOAD;
                lives_d = LIVES_INIT;
            end
            ST_LOAD:
                if (phase_q == PH_W'(LOAD_CYCLES - 1)) state_d = ST_SERVE;
            ST_SERVE:
                if (tick_w && phase_q == PH_W'(SERVE_TICKS - 1)) state_d = ST_PLAY;
            ST_PLAY: begin
                if (bricks == '0)
                    state_d = ST_WIN;
                else if (ball_lost)
                    state_d = ST_LOST;
`ifdef GAME_PAUSE_EN
                else if (start_edge)
                    state_d = ST_PAUSED;
`endif
            end
            ST_LOST: begin
                lives_d = (lives_q != '0) ? lives_q - 1'b1 : '0;
                state_d = (lives_q <= 1) ? ST_OVER : ST_SERVE;
            end
            ST_WIN, ST_OVER: if (start_edge) begin
                state_d = ST_LOAD;
                lives_d = LIVES_INIT;
            end
            ST_PAUSED: begin
`ifdef GAME_PAUSE_EN
                if (start_edge) state_d = ST_PLAY;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // LOAD counts cycles, SERVE counts ticks; both restart on state entry.
    always_comb begin
        phase_d = phase_q;
        if (state_d != state_q)
            phase_d = '0;
        else if (state_q == ST_LOAD || (state_q == ST_SERVE && tick_w))
            phase_d = phase_q + 1'b1;
    end

    // Entering or leaving PAUSED keeps the divider count so play resumes in phase.
    assign div_en   = (state_d == ST_SERVE) || (state_d == ST_PLAY);
    assign div_hold = (state_d == ST_PAUSED);
    assign div_clr  = (state_d != state_q) && (state_d != ST_PAUSED) && (state_q != ST_PAUSED);

    tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
        .clock (clock),
        .reset (reset),
        .en    (div_en),
        .clr   (div_clr),
        .hold  (div_hold),
        .tick  (tick_w)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lives_q <= LIVES_INIT;
            phase_q <= '0;
            start_q <= 1'b0;
            frn_q   <= 1'b1;
            hold_q  <= 1'b1;
            over_q  <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            phase_q <= phase_d;
            start_q <= start_btn;
            frn_q   <= (state_d != ST_LOAD);
            hold_q  <= !((state_d == ST_PLAY) || (state_d == ST_PAUSED));
            over_q  <= (state_d == ST_OVER);
            win_q   <= (state_d == ST_WIN);
        end
    end

    assign tick          = tick_w;
    assign field_reset_n = frn_q;
    assign ball_hold     = hold_q;
    assign lives         = lives_q;
    assign state         = state_q;
    assign game_over     = over_q;
    assign win           = win_q;

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level round controller for the brick-breaker game. It owns the game-step tick, sequences each round (load field, serve, play, life lost, win, game over), and drives the reset and enable controls of the ball, paddle and brick/score datapaths. It observes the 56-bit brick field and a ball-lost pulse to decide round outcomes.

Parameters:
TICK_DIV, 25000000, clock cycles per game tick (2 Hz at 50 MHz); minimum 2
LIVES, 3, lives at game start; range 1..3
SERVE_TICKS, 4, ticks the ball is held on the paddle before play
LOAD_CYCLES, 2, clock cycles field_reset_n is held low in LOAD

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
start_btn  in  1  debounced level; rising edge detected internally
bricks  in  56  brick field from scorer, 1 = brick present
ball_lost  in  1  one-clock pulse, ball passed below paddle
tick  out  1  one-clock game-step strobe, only in SERVE/PLAY
field_reset_n  out  1  active-low reset to brick/score datapath
ball_hold  out  1  1 = ball parked on paddle
lives  out  2  remaining lives
state  out  3  current state encoding
game_over  out  1  high in OVER
win  out  1  high in WIN

Behaviour:
- Reset (sync, high): state=IDLE, lives=LIVES, divider=0, start-edge register=0, tick=0, field_reset_n=1, ball_hold=1, game_over=0, win=0.
- start_edge = start_btn & ~start_btn_q (start_btn_q registered every cycle).
- Divider: counts 0..TICK_DIV-1 in SERVE and PLAY only; tick=1 for the single cycle where count==TICK_DIV-1, then wraps to 0. Cleared to 0 on every state entry.
- States: IDLE=0, LOAD=1, SERVE=2, PLAY=3, LOST=4, WIN=5, OVER=6, PAUSED=7.
- IDLE: ball_hold=1; start_edge -> LOAD, lives<=LIVES.
- LOAD: field_reset_n=0 for exactly LOAD_CYCLES cycles, then -> SERVE. Only LOAD drives field_reset_n low.
- SERVE: ball_hold=1; after SERVE_TICKS ticks -> PLAY. Serve-tick counter cleared on entry.
- PLAY: ball_hold=0. Priority: (1) bricks==0 -> WIN; (2) ball_lost -> LOST. bricks==0 and ball_lost in the same cycle -> WIN.
- LOST: one cycle; lives<=lives-1; if lives==1 -> OVER, else -> SERVE. The field is not reloaded.
- WIN/OVER: terminal; start_edge -> LOAD with lives<=LIVES.
- ball_lost outside PLAY is ignored. start_edge in SERVE/LOST is ignored.
- lives never underflows; it is 0 only in OVER.
- Outputs are registered (state-decoded Moore outputs; tick comes from a registered compare).
- Reset asserted mid-round returns to IDLE next edge regardless of state.

Optional Feature:
GAME_PAUSE_EN. When defined, start_edge in PLAY -> PAUSED. In PAUSED, the divider is frozen (not cleared), tick=0, ball_hold=0, and ball_lost and bricks are ignored. The next start_edge -> PLAY and the divider resumes from its held value. When undefined, state 7 is unreachable and start_edge in PLAY is ignored.

Decomposition:
- Package game_pkg: state enum (3-bit values above), BRICK_COUNT=56, LIVES_W=2, TICK_DIV default constant.
- Sub-module tick_divider: params TICK_DIV; ports clock, reset, en, clr, hold, tick. The sequencer instantiates it once.

Test Plan:
- Reset, then start_btn 0->1 with TICK_DIV=4, SERVE_TICKS=2, LOAD_CYCLES=2 -> LOAD for 2 cycles with field_reset_n=0; SERVE with ticks every 4 cycles; PLAY after the 2nd tick; ball_hold falls on PLAY entry.
- In PLAY with lives=3, pulse ball_lost -> LOST for 1 cycle, lives=2, then SERVE, then PLAY; field_reset_n stays 1.
- Three ball_lost events from LIVES=3 -> lives 2,1,0; state=OVER, game_over=1; further ball_lost pulses change nothing.
- In PLAY, drive bricks=0 in the same cycle as a ball_lost pulse -> WIN, win=1, lives unchanged; start_edge -> LOAD, lives=3.
- Hold start_btn high for 10 cycles in IDLE -> exactly one LOAD entry; assert reset mid-PLAY -> IDLE next edge with all outputs at reset values.
- With GAME_PAUSE_EN: start_edge at divider count 2 in PLAY -> PAUSED, no tick for 20 cycles; start_edge -> PLAY, first tick 1 cycle later (count resumes at 2→3).
